// File: rtl/writeback_arbiter_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// The buffered-result entry layout and the address decode live here so both levels agree.
package writeback_arbiter_pkg;

  localparam int WB_DATA_W     = 32;
  localparam int WB_REG_ADDR_W = 5;
  localparam int WB_NUM_REGS   = 1 << WB_REG_ADDR_W;

  typedef struct packed {
    logic                     valid;
    logic                     cancelled;
    logic [WB_REG_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0]     data;
  } wb_entry;

  function automatic logic [WB_NUM_REGS-1:0] rd_onehot(input logic [WB_REG_ADDR_W-1:0] r);
    logic [WB_NUM_REGS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of multi-cycle results awaiting a free write slot.
// Entries can be cancelled in place by destination register when a younger write overtakes them.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WB_REG_ADDR_W-1:0]     push_rd,
  input  logic [WB_DATA_W-1:0]         push_data,
  input  logic                         pop,
  input  logic                         cancel_en,
  input  logic [WB_REG_ADDR_W-1:0]     cancel_rd,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output wb_entry                      head,
  output logic [WB_NUM_REGS-1:0]       pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic                     valid_reg [DEPTH];
  logic                     canc_reg  [DEPTH];
  logic [WB_REG_ADDR_W-1:0] rd_reg    [DEPTH];
  logic [WB_DATA_W-1:0]     data_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_cancel;

  // An entry arriving in the same cycle as the overtaking write is born cancelled.
  assign push_cancel = cancel_en && (push_rd == cancel_rd);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_reg[gi] <= 1'b0;
        canc_reg[gi]  <= 1'b0;
        rd_reg[gi]    <= '0;
      end else if (push && wr_ptr_reg == PTR_W'(gi)) begin
        valid_reg[gi] <= 1'b1;
        canc_reg[gi]  <= push_cancel;
        rd_reg[gi]    <= push_rd;
      end else begin
        if (pop && rd_ptr_reg == PTR_W'(gi))
          valid_reg[gi] <= 1'b0;
        if (cancel_en && valid_reg[gi] && rd_reg[gi] == cancel_rd)
          canc_reg[gi] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      data_mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count = count_reg;

  always_comb begin
    head.valid     = valid_reg[rd_ptr_reg];
    head.cancelled = canc_reg[rd_ptr_reg];
    head.rd        = rd_reg[rd_ptr_reg];
    head.data      = data_mem[rd_ptr_reg];
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_reg[i] && !canc_reg[i] && rd_reg[i] != '0)
        pending = pending | rd_onehot(rd_reg[i]);
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges the single-cycle pipe (A, always wins) and the buffered multi-cycle unit (B)
// onto one registered register-file write port, exporting a mask of queued destinations.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int REG_ADDR_W = WB_REG_ADDR_W,
  parameter int DEPTH      = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_valid,
  input  logic [REG_ADDR_W-1:0]    a_rd,
  input  logic [DATA_W-1:0]        a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [REG_ADDR_W-1:0]    b_rd,
  input  logic [DATA_W-1:0]        b_data,
  output logic                     regWrite,
  output logic [REG_ADDR_W-1:0]    rd,
  output logic [DATA_W-1:0]        writeData,
  output logic [2**REG_ADDR_W-1:0] pending_mask
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [CNT_W-1:0]       fifo_count;
  wb_entry                fifo_head;
  logic [WB_NUM_REGS-1:0] fifo_pending;
  logic                   push;
  logic                   pop;
  logic                   cancel_en;

  logic                   sel_we;
  logic                   sel_load;
  logic [REG_ADDR_W-1:0]  sel_rd;
  logic [DATA_W-1:0]      sel_data;

  // Ready depends only on the registered occupancy, never on this cycle's valids.
  assign b_ready   = (fifo_count < CNT_W'(DEPTH));
  assign push      = b_valid && b_ready;
  assign pop       = !a_valid && (fifo_count != '0);
  assign cancel_en = a_valid && (a_rd != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_rd   (b_rd),
    .push_data (b_data),
    .pop       (pop),
    .cancel_en (cancel_en),
    .cancel_rd (a_rd),
    .count     (fifo_count),
    .head      (fifo_head),
    .pending   (fifo_pending)
  );

  always_comb begin
    sel_we   = 1'b0;
    sel_load = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    if (a_valid) begin
      sel_load = 1'b1;
      sel_rd   = a_rd;
      sel_data = a_data;
      sel_we   = (a_rd != '0);
    end else if (pop) begin
      // Cancelled and x0 entries still spend their slot, just without a write.
      sel_load = 1'b1;
      sel_rd   = fifo_head.rd;
      sel_data = fifo_head.data;
      sel_we   = fifo_head.valid && !fifo_head.cancelled && (fifo_head.rd != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regWrite  <= 1'b0;
      rd        <= '0;
      writeData <= '0;
    end else begin
      regWrite <= sel_we;
      if (sel_load) begin
        rd        <= sel_rd;
        writeData <= sel_data;
      end
    end
  end

  assign pending_mask = fifo_pending | (regWrite ? rd_onehot(rd) : '0);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_writeback_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        regWrite;
  logic [4:0]  rd;
  logic [31:0] writeData;
  logic [31:0] pending_mask;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  writeback_arbiter #(.DATA_W(32), .REG_ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_valid      (a_valid),
    .a_rd         (a_rd),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_rd         (b_rd),
    .b_data       (b_data),
    .regWrite     (regWrite),
    .rd           (rd),
    .writeData    (writeData),
    .pending_mask (pending_mask)
  );

  // Reference model: queued B results plus the expected write-port contents.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          canc;
  } ment_t;

  ment_t       q[$];
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (q[i])
      if (!q[i].canc && q[i].rd != 0) m[q[i].rd] = 1'b1;
    if (m_we) m[m_rd] = 1'b1;
    return m;
  endfunction

  task automatic model_edge();
    bit    accept;
    ment_t e;
    if (!rst_n) begin
      q.delete();
      m_we = 0; m_rd = '0; m_data = '0;
      return;
    end
    accept = b_valid && (q.size() < DEPTH);
    if (a_valid) begin
      m_we = (a_rd != 0); m_rd = a_rd; m_data = a_data;
      if (a_rd != 0)
        foreach (q[i]) if (q[i].rd == a_rd) q[i].canc = 1;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = !e.canc && (e.rd != 0); m_rd = e.rd; m_data = e.data;
    end else begin
      m_we = 0;
    end
    if (accept) begin
      e.rd = b_rd; e.data = b_data;
      e.canc = a_valid && (a_rd != 0) && (b_rd == a_rd);
      q.push_back(e);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    check("model_regWrite", {31'b0, regWrite}, {31'b0, m_we});
    if (m_we) begin
      check("model_rd", {27'b0, rd}, {27'b0, m_rd});
      check("model_writeData", writeData, m_data);
    end
    check("model_pending_mask", pending_mask, model_mask());
    check("model_b_ready", {31'b0, b_ready}, {31'b0, (q.size() < DEPTH)});
  endtask

  // Drive one cycle's inputs, clock it, update the model, then compare at the falling edge.
  task automatic step(input bit rn, input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit bv, input logic [4:0] brd, input logic [31:0] bd);
    rst_n = rn; a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
    $display("cyc t=%0t rst_n=%0b a=%0b/%0d b=%0b/%0d rdy=%0b -> we=%0b rd=%0d wd=%h mask=%h",
             $time, rn, av, ard, bv, brd, b_ready, regWrite, rd, writeData, pending_mask);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [4:0] b_order[$];
    int         idx;
    bit         acc;

    rst_n = 0; a_valid = 0; a_rd = 0; a_data = 0; b_valid = 0; b_rd = 0; b_data = 0;

    // Reset state
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("reset_regWrite", {31'b0, regWrite}, 32'd0);
    check("reset_rd", {27'b0, rd}, 32'd0);
    check("reset_writeData", writeData, 32'd0);
    check("reset_mask", pending_mask, 32'd0);
    check("reset_b_ready", {31'b0, b_ready}, 32'd1);

    // A only, then x0 suppression
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    check("a_only_regWrite", {31'b0, regWrite}, 32'd1);
    check("a_only_rd", {27'b0, rd}, 32'd5);
    check("a_only_data", writeData, 32'hDEADBEEF);
    check("a_only_mask", pending_mask, 32'h0000_0020);
    step(1, 1, 0, 32'h11111111, 0, 0, 0);
    check("a_x0_regWrite", {31'b0, regWrite}, 32'd0);
    idle();

    // B minimum latency
    step(1, 0, 0, 0, 1, 7, 32'h12345678);
    check("b_lat_t1_mask7", {31'b0, pending_mask[7]}, 32'd1);
    check("b_lat_t1_regWrite", {31'b0, regWrite}, 32'd0);
    idle();
    check("b_lat_t2_regWrite", {31'b0, regWrite}, 32'd1);
    check("b_lat_t2_rd", {27'b0, rd}, 32'd7);
    check("b_lat_t2_data", writeData, 32'h12345678);
    idle();
    check("b_lat_t3_mask7", {31'b0, pending_mask[7]}, 32'd0);

    // Backpressure: A held for 4 cycles while B offers rd 10,11,12
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) check("bp_ready_low_after_two", {31'b0, b_ready}, 32'd0);
      acc = b_ready && (idx < 3);
      step(1, c < 4, 5'(c + 1), 32'hA000_0000 + c, idx < 3, 5'(10 + idx), 32'hB000_0000 + idx);
      if (acc) idx++;
      if (regWrite && rd >= 10 && rd <= 12) b_order.push_back(rd);
    end
    check("bp_count", b_order.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < b_order.size()) check("bp_order", {27'b0, b_order[i]}, 32'(10 + i));

    // WAW cancel
    step(1, 0, 0, 0, 1, 9, 32'h0000_00B9);
    step(1, 1, 9, 32'h0000_00A9, 0, 0, 0);
    check("waw_a_regWrite", {31'b0, regWrite}, 32'd1);
    check("waw_a_data", writeData, 32'h0000_00A9);
    idle();
    check("waw_pop_regWrite", {31'b0, regWrite}, 32'd0);
    check("waw_mask9", {31'b0, pending_mask[9]}, 32'd0);
    idle();

    // Simultaneous push/pop at count=1 over 8 iterations
    step(1, 0, 0, 0, 1, 20, 32'hC000_0000);
    for (int i = 1; i <= 8; i++) begin
      check("pp_b_ready", {31'b0, b_ready}, 32'd1);
      step(1, 0, 0, 0, 1, 5'(20 + (i % 8)), 32'hC000_0000 + i);
      check("pp_regWrite", {31'b0, regWrite}, 32'd1);
      check("pp_data", writeData, 32'hC000_0000 + i - 1);
    end
    idle();
    idle();

    // Reset mid-stream with two queued entries
    step(1, 1, 1, 32'h1, 1, 14, 32'hE1);
    step(1, 1, 2, 32'h2, 1, 15, 32'hE2);
    step(0, 0, 0, 0, 0, 0, 0);
    check("rst_mid_regWrite", {31'b0, regWrite}, 32'd0);
    check("rst_mid_mask", pending_mask, 32'd0);
    check("rst_mid_b_ready", {31'b0, b_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("rst_mid_no_write", {31'b0, regWrite}, 32'd0);
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 4, 5'($urandom_range(0, 15)),
           $urandom, $urandom_range(0, 9) < 6, 5'($urandom_range(0, 15)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
